inemo_spi_serf: RTL
===================

// Module: inemo_spi_serf
// PURPOSE
// - Synthesizable SPI responder: the serf end of the 16-bit SPI link driven by the inertial interface's SPI monarch.
// - Provides a minimal gyro register map (WHO_AM_I, INT1_CTRL, yaw rate L/H) and an INT data-ready line.
// - Lets the full inertial path run on FPGA or in gate-level sim without the behavioural sensor model.
// - SCLK/SS_n/MOSI are oversampled in the clk domain; there is no SCLK-clocked logic.
// PARAMETERS
// - WHO_AM_I_VAL   8'h6A  value returned on a read of ADDR_WHO
// - ADDR_WHO       7'h0F  WHO_AM_I address (read-only)
// - ADDR_INT_CTRL  7'h0D  INT1_CTRL address (read/write)
// - ADDR_YAW_L     7'h26  yaw rate low byte (read-only)
// - ADDR_YAW_H     7'h27  yaw rate high byte (read-only)
// PORTS
// - clk        in   1   system clock
// - rst_n      in   1   asynchronous active-low reset
// - SS_n       in   1   select, active low (async, synchronized here)
// - SCLK       in   1   serial clock; idles high (async, synchronized here)
// - MOSI       in   1   serial data from monarch
// - MISO       out  1   serial data to monarch
// - yaw_rate   in   16  new gyro sample
// - yaw_vld    in   1   1-clk strobe: yaw_rate is valid
// - INT        out  1   data-ready interrupt, active high
// - int_ctrl   out  8   current INT1_CTRL contents
// - frm_done   out  1   1-clk pulse: a complete 16-bit frame ended
// - frm_err_cnt out 8   bad-frame count (only with SERF_FRAME_CHK_EN)
// BEHAVIOUR
// - Reset: MISO=0, INT=0, int_ctrl=8'h00, yaw regs=16'h0000, frm_done=0, frm_err_cnt=0. SS_n/SCLK sync flops reset to 1.
// - Sync: 2-flop synchronizers, plus a 3rd flop for edge detect on SS_n, SCLK and MOSI. Edge latency 3 clk.
//   Monarch SCLK half-period must be >= 6 clk.
// - Frame: 16 bits, MSB first. bit15=1 read / 0 write; bits14:8 address; bits7:0 write data or read return.
//   MOSI is sampled on SCLK rise. MISO changes on SCLK fall.
// - FSM IDLE -> SHIFT on SS_n fall: clear bit_cnt (4b+wrap flag) and shift reg.
//   - SHIFT: each SCLK rise shifts MOSI into rx_shft and increments bit_cnt.
//   - After rise #8: decode address. If read, load tx_shft with the register data on the next SCLK fall,
//     so data bit7 is on MISO before rise #9.
//   - SHIFT -> IDLE on SS_n rise. Frame is good iff exactly 16 rises occurred: then commit the write
//     (ADDR_INT_CTRL only) and pulse frm_done 1 clk after the SS_n rise is detected.
// - Bad frame (bit count != 16, or a 17th rise): discarded, no write, no frm_done, no INT clear.
// - Writes to any other address are ignored. Reads of unmapped addresses return 8'h00.
// - MISO = tx_shft[7] while SHIFT and read. Otherwise 0.
// - Data path: yaw_vld loads yaw regs from yaw_rate.
//   - If int_ctrl[1]=1, INT sets on the next clk. If int_ctrl[1]=0, INT stays 0.
//   - Reading ADDR_YAW_L snapshots the high byte into yaw_h_shadow.
//     A subsequent ADDR_YAW_H read returns the shadow, so the 16-bit value is coherent across a new sample.
//     ADDR_YAW_H with no prior L read returns the live high byte.
//   - A good read frame of ADDR_YAW_H clears INT at frm_done.
// - Simultaneous yaw_vld and INT clear in the same clk: INT stays 1 (set wins). The new sample is not lost.
// - Writing int_ctrl[1]=0 clears INT immediately at commit.
// - SS_n fall while in SHIFT (glitch/restart): restart the frame. Nothing is committed.
// - Async reset mid-frame aborts the frame. The next frame needs a fresh SS_n fall.
// CONFIGURATION
// - SERF_FRAME_CHK_EN defined:
//   - frm_err_cnt port present; increments (saturating at 8'hFF) on every bad frame.
//   - A read of address 7'h7F returns frm_err_cnt and clears it at frm_done.
// - SERF_FRAME_CHK_EN undefined:
//   - Port and counter absent. Bad frames are silently discarded. 7'h7F reads as 8'h00.
// TESTING
// - Read 16'h8F00 after reset -> MISO low byte 8'h6A, frm_done pulses once, INT=0.
// - Write 16'h0D02, then read 16'h8D00 -> int_ctrl=8'h02, read returns 8'h02.
// - int_ctrl=8'h02, yaw_vld with 16'hA5C3 -> INT=1 next clk.
//   Read 16'hA600 -> 8'hC3. Read 16'hA700 -> 8'hA5, INT=0 after frm_done.
// - Read 0x26 of 16'h1234, yaw_vld 16'h5678 before 0x27 read -> 0x27 returns 8'h12, INT remains 1.
// - SS_n raised after 10 bits on write 16'h0DFF -> int_ctrl unchanged, no frm_done.
//   With SERF_FRAME_CHK_EN, frm_err_cnt=1.
// - yaw_vld on the same clk as the INT-clearing frm_done -> INT=1. rst_n low mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/inemo_spi_serf.sv
// rtl/inemo_spi_serf.sv - 16-bit SPI serf with gyro register map and INT; SERF_FRAME_CHK_EN adds frm_err_cnt
module inemo_spi_serf #(
    parameter logic [7:0] WHO_AM_I_VAL  = 8'h6A,
    parameter logic [6:0] ADDR_WHO      = 7'h0F,
    parameter logic [6:0] ADDR_INT_CTRL = 7'h0D,
    parameter logic [6:0] ADDR_YAW_L    = 7'h26,
    parameter logic [6:0] ADDR_YAW_H    = 7'h27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] yaw_rate,
    input  logic        yaw_vld,
    output logic        INT,
    output logic [7:0]  int_ctrl,
    output logic        frm_done
`ifdef SERF_FRAME_CHK_EN
    ,
    output logic [7:0]  frm_err_cnt
`endif
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  ss_sync, sclk_sync, mosi_sync;
    logic [1:0]  init_cnt;
    logic        armed;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic        frm_start, frm_end, frm_good, commit;
    logic [3:0]  bit_cnt;
    logic        bit_wrap, bit_over, ld_pend, rd_frm;
    logic [15:0] rx_shft;
    logic [7:0]  tx_shft, rd_data;
    logic [7:0]  yaw_l, yaw_h, yaw_h_pend, yaw_h_shadow;
    logic        shadow_vld;
    logic        rd_load, wr_ctrl, rd_l_done, rd_h_done;

    // Three-stage synchronizers; stage 2 vs stage 1 gives the edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 3'b000;
        end else begin
            ss_sync   <= {ss_sync[1:0], SS_n};
            sclk_sync <= {sclk_sync[1:0], SCLK};
            mosi_sync <= {mosi_sync[1:0], MOSI};
        end
    end

    // Arm only after SS_n is seen high with real samples, so a reset taken
    // mid-frame cannot turn the reset-value-to-low transition into a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= 2'd0;
            armed    <= 1'b0;
        end else if (init_cnt != 2'd3) begin
            init_cnt <= init_cnt + 2'd1;
        end else if (ss_sync[2]) begin
            armed <= 1'b1;
        end
    end

    assign ss_fall   = armed & ss_sync[2] & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2] & ss_sync[1];
    assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
    assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state plus frame start/end strobes; a fall while shifting restarts
    always_comb begin
        state_nxt = state;
        frm_start = 1'b0;
        frm_end   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt = SHIFT;
                    frm_start = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_fall) begin
                    frm_start = 1'b1;
                end else if (ss_rise) begin
                    state_nxt = IDLE;
                    frm_end   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Wrap marks the 16th rise; any rise after that makes the frame bad
    assign frm_good  = bit_wrap & ~bit_over;
    assign commit    = frm_end & frm_good;
    assign rd_load   = (state == SHIFT) & ~frm_start & sclk_fall & ld_pend & rx_shft[7];
    assign wr_ctrl   = commit & ~rx_shft[15] & (rx_shft[14:8] == ADDR_INT_CTRL);
    assign rd_l_done = commit & rx_shft[15] & (rx_shft[14:8] == ADDR_YAW_L);
    assign rd_h_done = commit & rx_shft[15] & (rx_shft[14:8] == ADDR_YAW_H);

    // Read-return mux, decoded from the first eight received bits
    always_comb begin
        rd_data = 8'h00;
        case (rx_shft[6:0])
            ADDR_WHO:      rd_data = WHO_AM_I_VAL;
            ADDR_INT_CTRL: rd_data = int_ctrl;
            ADDR_YAW_L:    rd_data = yaw_l;
            ADDR_YAW_H:    rd_data = shadow_vld ? yaw_h_shadow : yaw_h;
`ifdef SERF_FRAME_CHK_EN
            7'h7F:         rd_data = frm_err_cnt;
`endif
            default:       rd_data = 8'h00;
        endcase
    end

    // Shift engine: MOSI in on SCLK rise, MISO data out on SCLK fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 4'd0;
            bit_wrap <= 1'b0;
            bit_over <= 1'b0;
            ld_pend  <= 1'b0;
            rd_frm   <= 1'b0;
            rx_shft  <= 16'h0000;
            tx_shft  <= 8'h00;
        end else if (frm_start) begin
            bit_cnt  <= 4'd0;
            bit_wrap <= 1'b0;
            bit_over <= 1'b0;
            ld_pend  <= 1'b0;
            rd_frm   <= 1'b0;
            rx_shft  <= 16'h0000;
            tx_shft  <= 8'h00;
        end else if (state == SHIFT) begin
            if (sclk_rise) begin
                rx_shft <= {rx_shft[14:0], mosi_sync[2]};
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_wrap) bit_over <= 1'b1;
                if (bit_cnt == 4'd15) bit_wrap <= 1'b1;
                if (bit_cnt == 4'd7 && !bit_wrap) ld_pend <= 1'b1;
            end else if (sclk_fall) begin
                if (ld_pend) begin
                    ld_pend <= 1'b0;
                    if (rx_shft[7]) begin
                        tx_shft <= rd_data;
                        rd_frm  <= 1'b1;
                    end
                end else begin
                    tx_shft <= {tx_shft[6:0], 1'b0};
                end
            end
        end
    end

    assign MISO = (state == SHIFT) & rd_frm & tx_shft[7];

    // Yaw sample registers; the high byte seen by an L read becomes the shadow
    // only once that read frame completes cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yaw_l        <= 8'h00;
            yaw_h        <= 8'h00;
            yaw_h_pend   <= 8'h00;
            yaw_h_shadow <= 8'h00;
            shadow_vld   <= 1'b0;
        end else begin
            if (yaw_vld) begin
                yaw_l <= yaw_rate[7:0];
                yaw_h <= yaw_rate[15:8];
            end
            if (rd_load && rx_shft[6:0] == ADDR_YAW_L) yaw_h_pend <= yaw_h;
            if (rd_l_done) begin
                yaw_h_shadow <= yaw_h_pend;
                shadow_vld   <= 1'b1;
            end else if (rd_h_done) begin
                shadow_vld <= 1'b0;
            end
        end
    end

    // Control register, interrupt (new sample beats a read clear) and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ctrl <= 8'h00;
            INT      <= 1'b0;
            frm_done <= 1'b0;
        end else begin
            frm_done <= commit;
            if (wr_ctrl) int_ctrl <= rx_shft[7:0];
            if (wr_ctrl && !rx_shft[1])        INT <= 1'b0;
            else if (yaw_vld && int_ctrl[1])   INT <= 1'b1;
            else if (rd_h_done)                INT <= 1'b0;
        end
    end

`ifdef SERF_FRAME_CHK_EN
    // Saturating bad-frame counter, cleared by a good read of 7'h7F
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_err_cnt <= 8'h00;
        end else if (frm_end && !frm_good) begin
            if (frm_err_cnt != 8'hFF) frm_err_cnt <= frm_err_cnt + 8'd1;
        end else if (commit && rx_shft[15] && rx_shft[14:8] == 7'h7F) begin
            frm_err_cnt <= 8'h00;
        end
    end
`endif

endmodule
